route_lock_ctrl: RTL and testbench
==================================

# route_lock_ctrl

Sequential route-setting controller on the request side of the ring interlock. It collects operator set and cancel requests for N routes and presents one candidate route at a time, together with the locked-route vector, to the combinational interlock array. It samples the array's clear/inhibit answer, then locks or rejects the candidate. Locked routes are held until a cancel, followed by a timed release.

## Interface

Parameters:
- `N_ROUTES`, default 8: number of routes (A..H). Bit i corresponds to route i.
- `RELEASE_CYCLES`, default 16: cycles from an accepted cancel to the lock bit dropping. Must be ≥1.

Ports:
- `i_Clk` in 1: single clock. All logic is on the rising edge.
- `i_Rst_n` in 1: reset, asynchronous, active-low.
- `i_Req` in N_ROUTES: route set requests. A bit high on an edge registers a request for that route.
- `i_Cancel` in N_ROUTES: route cancel requests, sampled on each edge.
- `i_Ok` in 1: interlock answer for the current candidate. 1 = no conflict (clear). 0 = inhibited.
- `o_ChkVec` out N_ROUTES: vector driven to the interlock array inputs. Equals `o_Lock | o_Cand`.
- `o_Cand` out N_ROUTES: one-hot candidate under check. All zeros when not checking.
- `o_Lock` out N_ROUTES: locked routes. Bits stay set during release timing.
- `o_Busy` out 1: high in PRESENT and SAMPLE.
- `o_Reject` out 1: one-cycle pulse when a candidate is inhibited.
- `o_RejectId` out clog2(N_ROUTES): index of the rejected route. Valid only with `o_Reject`; holds its last value otherwise.

Reset values: all outputs 0, pending vector 0, all timers 0, round-robin pointer 0, FSM in IDLE.

## Operation

- **Pending vector.** `pend[i]` is set by `i_Req[i]` unless `o_Lock[i]` is 1 (requests for locked routes are dropped silently). It is cleared by `i_Cancel[i]` or when route i is taken as candidate. If set and clear arrive on the same edge, clear wins.
- **Arbitration.** Round-robin. Select the first pending index at or above `ptr`, wrapping around. After SAMPLE, `ptr = (cand + 1) mod N_ROUTES`.
- **FSM states:**
  - IDLE: if `pend` is nonzero, load `o_Cand` with the selected route, clear its pend bit, go to PRESENT.
  - PRESENT: one settle cycle for the external combinational array. Go to SAMPLE.
  - SAMPLE: evaluate `i_Ok`.
    - `i_Ok=1`: set the lock bit.
    - `i_Ok=0`: pulse `o_Reject` with the route index.
    - In both cases clear `o_Cand` and return to IDLE.
- **Abort.** If `i_Cancel[cand]` arrives in PRESENT or SAMPLE, the candidate is aborted: no lock, no reject. `o_Cand` is cleared and the FSM returns to IDLE on that edge.
- **Release.** Each route has its own down-counter.
  - `i_Cancel[i]` while `o_Lock[i]=1` and the timer is 0 loads `RELEASE_CYCLES`.
  - The counter decrements every cycle. On the edge where it goes 1→0, `o_Lock[i]` clears.
  - A cancel during release timing does not restart the timer.
  - A cancel for an unlocked, non-pending route is ignored.
- **Concurrency.** Multiple routes may release concurrently. The FSM continues checking other candidates during releases, and releasing routes remain in `o_ChkVec`.
- **Mid-operation reset.** Reset while in PRESENT or SAMPLE discards the candidate, all pending requests, locks and timers immediately (asynchronous).

## Timing

- `i_Req[i]` sampled at edge k, FSM in IDLE: `o_Cand`/`o_Busy` are valid after edge k+1, `i_Ok` is sampled at edge k+3, and `o_Lock[i]` or `o_Reject` is visible after edge k+3.
  - The same request is not seen by IDLE until k+1, so the request-to-lock latency is 3 cycles.
- Back-to-back checks: 3 cycles per candidate (IDLE, PRESENT, SAMPLE).
- `i_Ok` is ignored outside SAMPLE.
- Cancel at edge c on a locked route: `o_Lock[i]` clears after edge c + `RELEASE_CYCLES`.
- `o_ChkVec` is fully registered, with no combinational path from inputs to outputs.

## Structure

- Package `route_pkg` holds:
  - the FSM state type (IDLE, PRESENT, SAMPLE);
  - the `N_ROUTES` default and the route-index width constant;
  - named route indices ROUTE_A..ROUTE_H.
- Sub-module `release_timer`, instantiated once per route via generate:
  - inputs: start, lock;
  - outputs: expire, active;
  - counter width `clog2(RELEASE_CYCLES+1)`.
- The round-robin picker is a function in the top module.

## Test plan

- **Single request.** Reset, `i_Req`=8'h80, `i_Ok`=1 → `o_Cand`=8'h80 for 2 cycles, `o_Lock`=8'h80 after 3 cycles, no `o_Reject`.
- **Conflict.** Lock route G, then `i_Req`=8'h80 with `i_Ok`=0 in SAMPLE → `o_Reject`=1 for one cycle, `o_RejectId`=7, `o_Lock` stays 8'h40.
- **Round-robin.** `i_Req`=8'h81 on the same edge, `ptr`=0, `i_Ok`=1 → route 0 locked after 3 cycles, route 7 after 6, `ptr`=0 at the end.
- **Release.** Locked 8'h01, `i_Cancel`=8'h01 at edge c, `RELEASE_CYCLES`=16 → lock bit drops exactly after edge c+16. A second cancel at c+5 does not extend it.
- **Abort and collisions.**
  - `i_Cancel` of the candidate during PRESENT → no lock, no reject, IDLE next.
  - `i_Req` and `i_Cancel` on the same bit and edge → `pend` stays 0.
- **Async reset.** `i_Rst_n` low mid-SAMPLE with a lock and an active timer → all outputs 0 immediately and stay 0 until the first new request.

Source files
------------

// File: rtl/route_pkg.sv
// Shared types and constants for the route-setting controller.
// Route indices name bit positions in every route vector.
package route_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SAMPLE  = 2'd2
    } state_e;

    localparam int N_ROUTES_DEF = 8;
    localparam int ROUTE_IDX_W  = $clog2(N_ROUTES_DEF);

    localparam logic [ROUTE_IDX_W-1:0] ROUTE_A = ROUTE_IDX_W'(0);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_B = ROUTE_IDX_W'(1);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_C = ROUTE_IDX_W'(2);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_D = ROUTE_IDX_W'(3);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_E = ROUTE_IDX_W'(4);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_F = ROUTE_IDX_W'(5);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_G = ROUTE_IDX_W'(6);
    localparam logic [ROUTE_IDX_W-1:0] ROUTE_H = ROUTE_IDX_W'(7);

endpackage

// File: rtl/release_timer.sv
// Per-route release down-counter: loaded on an accepted cancel, it flags
// expiry on the cycle whose edge takes it from 1 to 0.
module release_timer #(
    parameter int RELEASE_CYCLES = 16
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Start,
    input  logic i_Lock,
    output logic o_Expire,
    output logic o_Active
);

    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_Lock) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (i_Start) begin
            cnt_d = CNT_W'(RELEASE_CYCLES);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Expire = i_Lock && (cnt_q == CNT_W'(1));
    assign o_Active = (cnt_q != '0);

endmodule

// File: rtl/route_lock_ctrl.sv
// Request-side route controller: queues set requests, presents one candidate at
// a time to the interlock array, then locks or rejects it; cancels time out locks.
module route_lock_ctrl
    import route_pkg::*;
#(
    parameter int N_ROUTES       = N_ROUTES_DEF,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic [N_ROUTES-1:0]         i_Req,
    input  logic [N_ROUTES-1:0]         i_Cancel,
    input  logic                        i_Ok,
    output logic [N_ROUTES-1:0]         o_ChkVec,
    output logic [N_ROUTES-1:0]         o_Cand,
    output logic [N_ROUTES-1:0]         o_Lock,
    output logic                        o_Busy,
    output logic                        o_Reject,
    output logic [$clog2(N_ROUTES)-1:0] o_RejectId
);

    localparam int IDX_W = $clog2(N_ROUTES);

    state_e             state_q, state_d;
    logic [N_ROUTES-1:0] pend_q, pend_d;
    logic [N_ROUTES-1:0] lock_q, lock_d;
    logic [N_ROUTES-1:0] cand_q, cand_d;
    logic [N_ROUTES-1:0] chkVec_q, chkVec_d;
    logic [IDX_W-1:0]    candIdx_q, candIdx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    rejectId_q, rejectId_d;
    logic                reject_q, reject_d;
    logic                busy_q, busy_d;

    logic [N_ROUTES-1:0] expire;
    logic [N_ROUTES-1:0] active;
    logic [N_ROUTES-1:0] relStart;
    logic [N_ROUTES-1:0] lockSet;
    logic [N_ROUTES-1:0] take;
    logic [N_ROUTES-1:0] pickOneHot;
    logic [IDX_W-1:0]    pickIdx;
    logic [IDX_W-1:0]    nextPtr;
    logic                abort;

    // First pending index at or above ptr, wrapping; iterate downward so the
    // nearest match is the last one written.
    function automatic logic [IDX_W-1:0] pickRoute(input logic [N_ROUTES-1:0] pend,
                                                   input logic [IDX_W-1:0]    ptr);
        logic [IDX_W-1:0] sel;
        int               idx;
        sel = ptr;
        for (int k = N_ROUTES - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_ROUTES;
            if (pend[idx[IDX_W-1:0]]) begin
                sel = idx[IDX_W-1:0];
            end
        end
        return sel;
    endfunction

    for (genvar g = 0; g < N_ROUTES; g++) begin : g_timer
        release_timer #(
            .RELEASE_CYCLES(RELEASE_CYCLES)
        ) u_timer (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Start (relStart[g]),
            .i_Lock  (lock_q[g]),
            .o_Expire(expire[g]),
            .o_Active(active[g])
        );
    end

    assign relStart = i_Cancel & lock_q & ~active;
    assign pickIdx  = pickRoute(pend_q, ptr_q);
    assign nextPtr  = (candIdx_q == IDX_W'(N_ROUTES - 1)) ? '0 : candIdx_q + IDX_W'(1);
    assign abort    = |(i_Cancel & cand_q);

    always_comb begin
        pickOneHot          = '0;
        pickOneHot[pickIdx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        candIdx_d  = candIdx_q;
        ptr_d      = ptr_q;
        reject_d   = 1'b0;
        rejectId_d = rejectId_q;
        lockSet    = '0;
        take       = '0;

        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    candIdx_d = pickIdx;
                    cand_d    = pickOneHot;
                    take      = pickOneHot;
                    state_d   = PRESENT;
                end
            end
            PRESENT: begin
                if (abort) begin
                    cand_d  = '0;
                    state_d = IDLE;
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    cand_d  = '0;
                    state_d = IDLE;
                end else begin
                    if (i_Ok) begin
                        lockSet = cand_q;
                    end else begin
                        reject_d   = 1'b1;
                        rejectId_d = candIdx_q;
                    end
                    cand_d  = '0;
                    ptr_d   = nextPtr;
                    state_d = IDLE;
                end
            end
            default: begin
                cand_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Clear (cancel or candidate take) beats a same-edge set.
        pend_d   = (pend_q | (i_Req & ~lock_q)) & ~i_Cancel & ~take;
        lock_d   = (lock_q | lockSet) & ~expire;
        chkVec_d = lock_d | cand_d;
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            lock_q     <= '0;
            cand_q     <= '0;
            chkVec_q   <= '0;
            candIdx_q  <= '0;
            ptr_q      <= '0;
            rejectId_q <= '0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            lock_q     <= lock_d;
            cand_q     <= cand_d;
            chkVec_q   <= chkVec_d;
            candIdx_q  <= candIdx_d;
            ptr_q      <= ptr_d;
            rejectId_q <= rejectId_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
        end
    end

    assign o_ChkVec   = chkVec_q;
    assign o_Cand     = cand_q;
    assign o_Lock     = lock_q;
    assign o_Busy     = busy_q;
    assign o_Reject   = reject_q;
    assign o_RejectId = rejectId_q;

endmodule

// File: tb/tb_route_lock_ctrl.sv
// Directed bench for route_lock_ctrl: lock, reject, round-robin, release timing,
// abort, request/cancel collision and asynchronous reset.
module tb_route_lock_ctrl;

    logic       i_Clk;
    logic       i_Rst_n;
    logic [7:0] i_Req;
    logic [7:0] i_Cancel;
    logic       i_Ok;
    logic [7:0] o_ChkVec;
    logic [7:0] o_Cand;
    logic [7:0] o_Lock;
    logic       o_Busy;
    logic       o_Reject;
    logic [2:0] o_RejectId;

    int total = 0;
    int bad   = 0;

    route_lock_ctrl #(
        .N_ROUTES      (8),
        .RELEASE_CYCLES(16)
    ) dut (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Req     (i_Req),
        .i_Cancel  (i_Cancel),
        .i_Ok      (i_Ok),
        .o_ChkVec  (o_ChkVec),
        .o_Cand    (o_Cand),
        .o_Lock    (o_Lock),
        .o_Busy    (o_Busy),
        .o_Reject  (o_Reject),
        .o_RejectId(o_RejectId)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic [7:0] cancel, input logic ok);
        i_Req    = req;
        i_Cancel = cancel;
        i_Ok     = ok;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(8'h00, 8'h00, 1'b0);
        i_Rst_n = 1'b0;
        tick();
        tick();
        i_Rst_n = 1'b1;
    endtask

    // Request one route with i_Ok=1 and wait until its lock bit is visible.
    task automatic lockRoute(input logic [7:0] route);
        applyStimulus(route, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        tick();
        tick();
    endtask

    initial begin
        i_Rst_n = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0);
        $display("[TB] start");

        doReset();
        checkOutput("rst_lock", o_Lock, 8'h00);
        checkOutput("rst_cand", o_Cand, 8'h00);
        checkOutput("rst_chk", o_ChkVec, 8'h00);
        checkOutput("rst_busy", 8'(o_Busy), 8'h00);
        checkOutput("rst_rej", 8'(o_Reject), 8'h00);
        checkOutput("rst_rejid", 8'(o_RejectId), 8'h00);

        // Single request on route H
        applyStimulus(8'h80, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("single_k_cand", o_Cand, 8'h00);
        checkOutput("single_k_busy", 8'(o_Busy), 8'h00);
        tick();
        checkOutput("single_k1_cand", o_Cand, 8'h80);
        checkOutput("single_k1_busy", 8'(o_Busy), 8'h01);
        checkOutput("single_k1_chk", o_ChkVec, 8'h80);
        checkOutput("single_k1_lock", o_Lock, 8'h00);
        tick();
        checkOutput("single_k2_cand", o_Cand, 8'h80);
        checkOutput("single_k2_lock", o_Lock, 8'h00);
        tick();
        checkOutput("single_k3_lock", o_Lock, 8'h80);
        checkOutput("single_k3_cand", o_Cand, 8'h00);
        checkOutput("single_k3_busy", 8'(o_Busy), 8'h00);
        checkOutput("single_k3_rej", 8'(o_Reject), 8'h00);
        checkOutput("single_k3_chk", o_ChkVec, 8'h80);

        // Conflict: G locked, H inhibited
        doReset();
        lockRoute(8'h40);
        checkOutput("conf_lockG", o_Lock, 8'h40);
        applyStimulus(8'h80, 8'h00, 1'b0);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("conf_cand", o_Cand, 8'h80);
        checkOutput("conf_chk", o_ChkVec, 8'hC0);
        tick();
        checkOutput("conf_pre_rej", 8'(o_Reject), 8'h00);
        tick();
        checkOutput("conf_rej", 8'(o_Reject), 8'h01);
        checkOutput("conf_rejid", 8'(o_RejectId), 8'h07);
        checkOutput("conf_lock", o_Lock, 8'h40);
        checkOutput("conf_cand0", o_Cand, 8'h00);
        tick();
        checkOutput("conf_rej_pulse", 8'(o_Reject), 8'h00);
        checkOutput("conf_rejid_hold", 8'(o_RejectId), 8'h07);

        // Round-robin: A then H, pointer wraps back to 0
        doReset();
        applyStimulus(8'h81, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("rr_cand_a", o_Cand, 8'h01);
        tick();
        tick();
        checkOutput("rr_lock_a", o_Lock, 8'h01);
        tick();
        checkOutput("rr_cand_h", o_Cand, 8'h80);
        checkOutput("rr_chk_h", o_ChkVec, 8'h81);
        tick();
        tick();
        checkOutput("rr_lock_h", o_Lock, 8'h81);
        applyStimulus(8'h06, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("rr_ptr_wrap", o_Cand, 8'h02);

        // Release timing with a second cancel and a concurrent check
        doReset();
        lockRoute(8'h01);
        applyStimulus(8'h00, 8'h01, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h02, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("rel_cand_b", o_Cand, 8'h02);
        checkOutput("rel_chk_b", o_ChkVec, 8'h03);
        tick();
        applyStimulus(8'h00, 8'h01, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("rel_c5_lock", o_Lock, 8'h03);
        for (int i = 6; i <= 15; i++) tick();
        checkOutput("rel_c15_lock", o_Lock, 8'h03);
        tick();
        checkOutput("rel_c16_lock", o_Lock, 8'h02);
        checkOutput("rel_c16_chk", o_ChkVec, 8'h02);

        // Abort during PRESENT, then request/cancel collision
        doReset();
        applyStimulus(8'h04, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("abort_cand", o_Cand, 8'h04);
        applyStimulus(8'h00, 8'h04, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("abort_cand0", o_Cand, 8'h00);
        checkOutput("abort_busy", 8'(o_Busy), 8'h00);
        tick();
        checkOutput("abort_lock", o_Lock, 8'h00);
        checkOutput("abort_rej", 8'(o_Reject), 8'h00);
        checkOutput("abort_busy2", 8'(o_Busy), 8'h00);
        applyStimulus(8'h08, 8'h08, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("coll_cand", o_Cand, 8'h00);
        checkOutput("coll_busy", 8'(o_Busy), 8'h00);
        tick();
        checkOutput("coll_lock", o_Lock, 8'h00);

        // Asynchronous reset in SAMPLE with a lock and a running timer
        doReset();
        lockRoute(8'h01);
        applyStimulus(8'h02, 8'h01, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        tick();
        checkOutput("ar_pre_cand", o_Cand, 8'h02);
        checkOutput("ar_pre_lock", o_Lock, 8'h01);
        #2;
        i_Rst_n = 1'b0;
        #1;
        checkOutput("ar_lock", o_Lock, 8'h00);
        checkOutput("ar_cand", o_Cand, 8'h00);
        checkOutput("ar_chk", o_ChkVec, 8'h00);
        checkOutput("ar_busy", 8'(o_Busy), 8'h00);
        checkOutput("ar_rej", 8'(o_Reject), 8'h00);
        #2;
        i_Rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("ar_hold_lock", o_Lock, 8'h00);
        checkOutput("ar_hold_busy", 8'(o_Busy), 8'h00);
        checkOutput("ar_hold_chk", o_ChkVec, 8'h00);
        applyStimulus(8'h10, 8'h00, 1'b1);
        tick();
        applyStimulus(8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("ar_new_cand", o_Cand, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
